// File: rtl/instr_mem_pkg.sv
// Shared types and address helpers for the instruction-memory responder.
// The error check is only used when INSTR_RAM_RESP_ERR_EN is defined.
package instr_mem_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } instr_resp_t;

    // Word index relative to base, wrapped to the array size.
    function automatic logic [31:0] instr_index(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned depth
    );
        logic [31:0] off;
        off = addr - base;
        return (off >> 2) & (depth - 1);
    endfunction

    // Misaligned or outside [base, base + depth*4); compared at 33 bits to avoid wrap.
    function automatic logic instr_addr_err(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned depth
    );
        logic [32:0] lim;
        lim = {1'b0, base} + ({1'b0, depth} << 2);
        return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= lim);
    endfunction

endpackage

// File: rtl/instr_resp_stage.sv
// One response pipeline slot: valid/data/err register with compressing
// handshake (fills when empty or when its contents leave in the same cycle).
module instr_resp_stage
    import instr_mem_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fill_valid,
    input  instr_resp_t fill_resp,
    input  logic        drain_ready,
    output logic        valid,
    output instr_resp_t resp
);

    logic take;

    assign take = fill_valid && (!valid || drain_ready);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid <= 1'b0;
            resp  <= '0;
        end else if (take) begin
            valid <= 1'b1;
            resp  <= fill_resp;
        end else if (drain_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_ram_responder.sv
// Instruction RAM responder: word array with read-before-write load port and a
// LATENCY-deep valid/ready response pipeline. Optional macro: INSTR_RAM_RESP_ERR_EN.
module instr_ram_responder
    import instr_mem_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic        rready_i,
    input  logic        we_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] wdata_i
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]        mem [DEPTH];
    logic [AW-1:0]      rd_idx;
    logic [AW-1:0]      wr_idx;
    logic               rd_err;
    logic               wr_en;
    instr_resp_t        fetch;

    logic [LATENCY-1:0] valid;
    logic [LATENCY-1:0] fill_valid;
    logic [LATENCY:0]   ready;
    instr_resp_t        fill_resp [LATENCY];
    instr_resp_t        resp      [LATENCY];

    assign rd_idx = AW'(instr_index(addr_i, BASE_ADDR, DEPTH));
    assign wr_idx = AW'(instr_index(waddr_i, BASE_ADDR, DEPTH));

`ifdef INSTR_RAM_RESP_ERR_EN
    assign rd_err = instr_addr_err(addr_i, BASE_ADDR, DEPTH);
    assign wr_en  = we_i && !instr_addr_err(waddr_i, BASE_ADDR, DEPTH);
`else
    assign rd_err = 1'b0;
    assign wr_en  = we_i;
`endif

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_idx] <= wdata_i;
        end
    end

    // Stage 0 samples the array at the same edge as the write, so it sees old data.
    assign fetch.data = rd_err ? INSTR_NOP : mem[rd_idx];
    assign fetch.err  = rd_err;

    assign ready[LATENCY] = rready_i;

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        // Slot k can take new data if the consumer is ready or any slot from k onward is empty.
        assign ready[k] = rready_i || !(&valid[LATENCY-1:k]);

        if (k == 0) begin : g_head
            assign fill_valid[k] = req_i;
            assign fill_resp[k]  = fetch;
        end else begin : g_body
            assign fill_valid[k] = valid[k-1];
            assign fill_resp[k]  = resp[k-1];
        end

        instr_resp_stage u_stage (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .fill_valid  (fill_valid[k]),
            .fill_resp   (fill_resp[k]),
            .drain_ready (ready[k+1]),
            .valid       (valid[k]),
            .resp        (resp[k])
        );
    end

    assign gnt_o    = rst_ni && ready[0];
    assign rvalid_o = valid[LATENCY-1];
    assign rdata_o  = resp[LATENCY-1].data;
    assign err_o    = resp[LATENCY-1].err;

endmodule
